// File: rtl/ofs_plat_avalon_mem_limiter_pkg.sv
// ofs_plat_avalon_mem_limiter_pkg: shared types and helpers for the Avalon outstanding-request limiter
// Holds the response type, the write burst state encoding and the max-burst helper.
package ofs_plat_avalon_mem_limiter_pkg;
  typedef logic [1:0] t_response;
  typedef enum logic {SOP, IN_BURST} t_wr_burst_state;
  function automatic int burst_max(input int bcw);
    return 1 << (bcw - 1);
  endfunction
endpackage

// File: rtl/ofs_plat_avalon_mem_burst_tracker.sv
// ofs_plat_avalon_mem_burst_tracker: tracks start-of-packet vs in-burst position on an Avalon write stream
// Ports: clk, rst (async, active-high); fire = write beat accepted this cycle;
// burstcount = burstcount of the beat; is_sop = next accepted beat starts a new burst.
module ofs_plat_avalon_mem_burst_tracker
  import ofs_plat_avalon_mem_limiter_pkg::*;
#(
  parameter int BURST_CNT_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fire,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  output logic                       is_sop
);
  t_wr_burst_state state, state_n;
  logic [BURST_CNT_WIDTH-1:0] left, left_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SOP;
      left  <= '0;
    end else begin
      state <= state_n;
      left  <= left_n;
    end
  end
  // burstcount is only meaningful on the SOP beat; later beats just count down
  always_comb begin
    state_n = state;
    left_n  = left;
    if (fire) begin
      left_n  = is_sop ? burstcount - 1'b1 : left - 1'b1;
      state_n = left_n == '0 ? SOP : IN_BURST;
    end
  end
  assign is_sop = state == SOP;
endmodule

// File: rtl/ofs_plat_avalon_mem_rdwr_if_outstanding_limiter.sv
// ofs_plat_avalon_mem_rdwr_if_outstanding_limiter: caps outstanding read beats and write bursts ahead of the rd/wr clock-crossing shim
// Ports: s_rd_*/s_wr_* face the upstream source, m_rd_*/m_wr_* face the shim. Request fields and
// responses pass straight through; only read/write valids and waitrequests are gated.
// rd_beats_outstanding / wr_bursts_outstanding expose the live counts for debug.
module ofs_plat_avalon_mem_rdwr_if_outstanding_limiter
  import ofs_plat_avalon_mem_limiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_RD_BEATS    = 128,
  parameter int MAX_WR_BURSTS   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_rd_read,
  input  logic [ADDR_WIDTH-1:0]           s_rd_address,
  input  logic [USER_WIDTH-1:0]           s_rd_user,
  input  logic [BURST_CNT_WIDTH-1:0]      s_rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]         s_rd_byteenable,
  output logic                            s_rd_waitrequest,
  output logic [DATA_WIDTH-1:0]           s_rd_readdata,
  output t_response                       s_rd_response,
  output logic                            s_rd_readdatavalid,
  input  logic                            s_wr_write,
  input  logic [ADDR_WIDTH-1:0]           s_wr_address,
  input  logic [USER_WIDTH-1:0]           s_wr_user,
  input  logic [BURST_CNT_WIDTH-1:0]      s_wr_burstcount,
  input  logic [DATA_WIDTH-1:0]           s_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]         s_wr_byteenable,
  output logic                            s_wr_waitrequest,
  output t_response                       s_wr_response,
  output logic                            s_wr_writeresponsevalid,
  output logic                            m_rd_read,
  output logic [ADDR_WIDTH-1:0]           m_rd_address,
  output logic [USER_WIDTH-1:0]           m_rd_user,
  output logic [BURST_CNT_WIDTH-1:0]      m_rd_burstcount,
  output logic [DATA_WIDTH/8-1:0]         m_rd_byteenable,
  input  logic                            m_rd_waitrequest,
  input  logic [DATA_WIDTH-1:0]           m_rd_readdata,
  input  t_response                       m_rd_response,
  input  logic                            m_rd_readdatavalid,
  output logic                            m_wr_write,
  output logic [ADDR_WIDTH-1:0]           m_wr_address,
  output logic [USER_WIDTH-1:0]           m_wr_user,
  output logic [BURST_CNT_WIDTH-1:0]      m_wr_burstcount,
  output logic [DATA_WIDTH-1:0]           m_wr_writedata,
  output logic [DATA_WIDTH/8-1:0]         m_wr_byteenable,
  input  logic                            m_wr_waitrequest,
  input  t_response                       m_wr_response,
  input  logic                            m_wr_writeresponsevalid,
  output logic [$clog2(MAX_RD_BEATS):0]   rd_beats_outstanding,
  output logic [$clog2(MAX_WR_BURSTS):0]  wr_bursts_outstanding
);
  localparam int RCW = $clog2(MAX_RD_BEATS) + 1;
  localparam int WCW = $clog2(MAX_WR_BURSTS) + 1;
  localparam int BW  = BURST_CNT_WIDTH + 1;
  localparam int RW  = RCW + 1;
  localparam int WW  = WCW + 1;
  localparam logic [RCW-1:0] RD_MAX = RCW'(MAX_RD_BEATS);
  localparam logic [WCW-1:0] WR_MAX = WCW'(MAX_WR_BURSTS);
  localparam logic [BW-1:0]  B_MAX  = BW'(burst_max(BURST_CNT_WIDTH));

  if (MAX_RD_BEATS < burst_max(BURST_CNT_WIDTH)) begin : g_bad_rd
    $error("MAX_RD_BEATS must be at least the maximum burst size");
  end
  if (MAX_WR_BURSTS < 1) begin : g_bad_wr
    $error("MAX_WR_BURSTS must be at least 1");
  end

  logic [RCW-1:0] rd_cnt;
  logic [WCW-1:0] wr_cnt;
  logic [RW-1:0]  rd_sum;
  logic [WW-1:0]  wr_sum;
  logic rd_allow, wr_allow, rd_fire, wr_fire, is_sop;

  assign m_rd_address    = s_rd_address;
  assign m_rd_user       = s_rd_user;
  assign m_rd_burstcount = s_rd_burstcount;
  assign m_rd_byteenable = s_rd_byteenable;
  assign m_wr_address    = s_wr_address;
  assign m_wr_user       = s_wr_user;
  assign m_wr_burstcount = s_wr_burstcount;
  assign m_wr_writedata  = s_wr_writedata;
  assign m_wr_byteenable = s_wr_byteenable;
  assign s_rd_readdata           = m_rd_readdata;
  assign s_rd_response           = m_rd_response;
  assign s_rd_readdatavalid      = m_rd_readdatavalid;
  assign s_wr_response           = m_wr_response;
  assign s_wr_writeresponsevalid = m_wr_writeresponsevalid;

  // allow terms come only from registered counts so waitrequest never loops back through the shim
  assign rd_allow = (RD_MAX - rd_cnt) >= RCW'(s_rd_burstcount);
  assign wr_allow = !is_sop || wr_cnt < WR_MAX;

  assign m_rd_read        = !reset && s_rd_read && rd_allow;
  assign s_rd_waitrequest = reset || m_rd_waitrequest || !rd_allow;
  assign m_wr_write       = !reset && s_wr_write && wr_allow;
  assign s_wr_waitrequest = reset || m_wr_waitrequest || !wr_allow;

  assign rd_fire = m_rd_read && !m_rd_waitrequest;
  assign wr_fire = m_wr_write && !m_wr_waitrequest;

  // responses against an empty count saturate at zero instead of wrapping
  assign rd_sum = {1'b0, rd_cnt} + (rd_fire ? RW'(s_rd_burstcount) : '0);
  assign wr_sum = {1'b0, wr_cnt} + WW'(wr_fire && is_sop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      rd_cnt <= RCW'(m_rd_readdatavalid && rd_sum != '0 ? rd_sum - 1'b1 : rd_sum);
      wr_cnt <= WCW'(m_wr_writeresponsevalid && wr_sum != '0 ? wr_sum - 1'b1 : wr_sum);
    end
  end

  assign rd_beats_outstanding  = rd_cnt;
  assign wr_bursts_outstanding = wr_cnt;

  ofs_plat_avalon_mem_burst_tracker #(.BURST_CNT_WIDTH(BURST_CNT_WIDTH)) u_tracker (
    .clk       (clk),
    .rst       (reset),
    .fire      (wr_fire),
    .burstcount(s_wr_burstcount),
    .is_sop    (is_sop)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(m_rd_readdatavalid && rd_sum == '0)) else $fatal(1, "%m: read response with no beats outstanding");
      assert (!(m_wr_writeresponsevalid && wr_sum == '0)) else $fatal(1, "%m: write response with no bursts outstanding");
      assert (!s_rd_read || (s_rd_burstcount != '0 && {1'b0, s_rd_burstcount} <= B_MAX)) else $fatal(1, "%m: illegal read burstcount");
      assert (!(s_wr_write && is_sop) || (s_wr_burstcount != '0 && {1'b0, s_wr_burstcount} <= B_MAX)) else $fatal(1, "%m: illegal write burstcount");
      assert (rd_cnt <= RD_MAX) else $fatal(1, "%m: read beat count above limit");
      assert (wr_cnt <= WR_MAX) else $fatal(1, "%m: write burst count above limit");
    end
  end
endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_if_outstanding_limiter.sv
// tb_ofs_plat_avalon_mem_rdwr_if_outstanding_limiter: directed bench with a per-cycle behavioural model of the limiter
module tb_ofs_plat_avalon_mem_rdwr_if_outstanding_limiter;
  localparam int AW = 32, DW = 64, BCW = 7, UW = 1, MRB = 128, MWB = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic s_rd_read, s_rd_waitrequest, s_rd_readdatavalid;
  logic [AW-1:0] s_rd_address;
  logic [UW-1:0] s_rd_user;
  logic [BCW-1:0] s_rd_burstcount;
  logic [DW/8-1:0] s_rd_byteenable;
  logic [DW-1:0] s_rd_readdata;
  logic [1:0] s_rd_response;
  logic s_wr_write, s_wr_waitrequest, s_wr_writeresponsevalid;
  logic [AW-1:0] s_wr_address;
  logic [UW-1:0] s_wr_user;
  logic [BCW-1:0] s_wr_burstcount;
  logic [DW-1:0] s_wr_writedata;
  logic [DW/8-1:0] s_wr_byteenable;
  logic [1:0] s_wr_response;
  logic m_rd_read, m_rd_waitrequest, m_rd_readdatavalid;
  logic [AW-1:0] m_rd_address;
  logic [UW-1:0] m_rd_user;
  logic [BCW-1:0] m_rd_burstcount;
  logic [DW/8-1:0] m_rd_byteenable;
  logic [DW-1:0] m_rd_readdata;
  logic [1:0] m_rd_response;
  logic m_wr_write, m_wr_waitrequest, m_wr_writeresponsevalid;
  logic [AW-1:0] m_wr_address;
  logic [UW-1:0] m_wr_user;
  logic [BCW-1:0] m_wr_burstcount;
  logic [DW-1:0] m_wr_writedata;
  logic [DW/8-1:0] m_wr_byteenable;
  logic [1:0] m_wr_response;
  logic [$clog2(MRB):0] rd_beats_outstanding;
  logic [$clog2(MWB):0] wr_bursts_outstanding;

  ofs_plat_avalon_mem_rdwr_if_outstanding_limiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .USER_WIDTH(UW),
    .MAX_RD_BEATS(MRB), .MAX_WR_BURSTS(MWB)
  ) dut (
    .clk(clk), .reset(reset),
    .s_rd_read(s_rd_read), .s_rd_address(s_rd_address), .s_rd_user(s_rd_user),
    .s_rd_burstcount(s_rd_burstcount), .s_rd_byteenable(s_rd_byteenable),
    .s_rd_waitrequest(s_rd_waitrequest), .s_rd_readdata(s_rd_readdata),
    .s_rd_response(s_rd_response), .s_rd_readdatavalid(s_rd_readdatavalid),
    .s_wr_write(s_wr_write), .s_wr_address(s_wr_address), .s_wr_user(s_wr_user),
    .s_wr_burstcount(s_wr_burstcount), .s_wr_writedata(s_wr_writedata),
    .s_wr_byteenable(s_wr_byteenable), .s_wr_waitrequest(s_wr_waitrequest),
    .s_wr_response(s_wr_response), .s_wr_writeresponsevalid(s_wr_writeresponsevalid),
    .m_rd_read(m_rd_read), .m_rd_address(m_rd_address), .m_rd_user(m_rd_user),
    .m_rd_burstcount(m_rd_burstcount), .m_rd_byteenable(m_rd_byteenable),
    .m_rd_waitrequest(m_rd_waitrequest), .m_rd_readdata(m_rd_readdata),
    .m_rd_response(m_rd_response), .m_rd_readdatavalid(m_rd_readdatavalid),
    .m_wr_write(m_wr_write), .m_wr_address(m_wr_address), .m_wr_user(m_wr_user),
    .m_wr_burstcount(m_wr_burstcount), .m_wr_writedata(m_wr_writedata),
    .m_wr_byteenable(m_wr_byteenable), .m_wr_waitrequest(m_wr_waitrequest),
    .m_wr_response(m_wr_response), .m_wr_writeresponsevalid(m_wr_writeresponsevalid),
    .rd_beats_outstanding(rd_beats_outstanding),
    .wr_bursts_outstanding(wr_bursts_outstanding)
  );

  int n_checks = 0;
  int n_fail = 0;
  int mdl_rd = 0;
  int mdl_wr = 0;
  int mdl_rem = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic e_rd_allow();
    return (MRB - mdl_rd) >= int'(s_rd_burstcount);
  endfunction

  function automatic logic e_wr_allow();
    return mdl_rem > 0 || mdl_wr < MWB;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_rd = 0;
      mdl_wr = 0;
      mdl_rem = 0;
    end else begin
      if (s_rd_read && e_rd_allow() && !m_rd_waitrequest) mdl_rd += int'(s_rd_burstcount);
      if (m_rd_readdatavalid && mdl_rd > 0) mdl_rd -= 1;
      if (s_wr_write && e_wr_allow() && !m_wr_waitrequest) begin
        if (mdl_rem == 0) begin
          mdl_wr += 1;
          mdl_rem = int'(s_wr_burstcount) - 1;
        end else mdl_rem -= 1;
      end
      if (m_wr_writeresponsevalid && mdl_wr > 0) mdl_wr -= 1;
    end
  end

  always @(negedge clk) begin
    chk("m_rd_read", m_rd_read, !reset && s_rd_read && e_rd_allow());
    chk("s_rd_waitrequest", s_rd_waitrequest, reset || m_rd_waitrequest || !e_rd_allow());
    chk("m_wr_write", m_wr_write, !reset && s_wr_write && e_wr_allow());
    chk("s_wr_waitrequest", s_wr_waitrequest, reset || m_wr_waitrequest || !e_wr_allow());
    chk("rd_beats_outstanding", rd_beats_outstanding, mdl_rd);
    chk("wr_bursts_outstanding", wr_bursts_outstanding, mdl_wr);
    chk("pt_rd_address", m_rd_address, s_rd_address);
    chk("pt_rd_burstcount", m_rd_burstcount, s_rd_burstcount);
    chk("pt_wr_writedata", m_wr_writedata, s_wr_writedata);
    chk("pt_wr_byteenable", m_wr_byteenable, s_wr_byteenable);
    chk("pt_rd_readdata", s_rd_readdata, m_rd_readdata);
    chk("pt_rd_resp", {s_rd_response, s_rd_readdatavalid}, {m_rd_response, m_rd_readdatavalid});
    chk("pt_wr_resp", {s_wr_response, s_wr_writeresponsevalid}, {m_wr_response, m_wr_writeresponsevalid});
  end

  task automatic rnd();
    s_rd_address = $urandom;
    s_rd_user = UW'($urandom);
    s_rd_byteenable = DW/8'($urandom);
    s_wr_address = $urandom;
    s_wr_user = UW'($urandom);
    s_wr_writedata = {$urandom, $urandom};
    s_wr_byteenable = DW/8'($urandom);
    m_rd_readdata = {$urandom, $urandom};
    m_rd_response = 2'($urandom_range(0, 3));
    m_wr_response = 2'($urandom_range(0, 3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rnd();
  endtask

  task automatic gated(input string tag);
    chk({tag, "_m_rd_read"}, m_rd_read, 1'b0);
    chk({tag, "_s_rd_wait"}, s_rd_waitrequest, 1'b1);
    chk({tag, "_m_wr_write"}, m_wr_write, 1'b0);
    chk({tag, "_s_wr_wait"}, s_wr_waitrequest, 1'b1);
  endtask

  initial begin
    s_rd_read = 0; s_rd_burstcount = 1; s_wr_write = 0; s_wr_burstcount = 1;
    m_rd_waitrequest = 0; m_rd_readdatavalid = 0;
    m_wr_waitrequest = 0; m_wr_writeresponsevalid = 0;
    rnd();
    step(); step();
    s_rd_read = 1; s_rd_burstcount = 4; s_wr_write = 1; s_wr_burstcount = 3; #1;
    gated("in_reset");
    step();
    reset = 0;
    step();
    chk("mid_rd_cnt", rd_beats_outstanding, 4);
    chk("mid_wr_cnt", wr_bursts_outstanding, 1);
    reset = 1; #1;
    gated("mid_reset");
    chk("mid_reset_rd_cnt", rd_beats_outstanding, 0);
    chk("mid_reset_wr_cnt", wr_bursts_outstanding, 0);
    s_rd_read = 0; s_wr_write = 0; s_rd_burstcount = 1;
    step();
    reset = 0;
    step();
    chk("post_reset_rd_cnt", rd_beats_outstanding, 0);
    chk("post_reset_wr_cnt", wr_bursts_outstanding, 0);
    s_wr_write = 1; s_wr_burstcount = 1;
    step();
    s_wr_write = 0;
    chk("post_reset_sop", wr_bursts_outstanding, 1);
    m_wr_writeresponsevalid = 1;
    step();
    m_wr_writeresponsevalid = 0;
    chk("wr_drained0", wr_bursts_outstanding, 0);

    s_rd_read = 1; s_rd_burstcount = 64;
    step(); step();
    chk("rd_full", rd_beats_outstanding, 128);
    s_rd_burstcount = 1; #1;
    chk("rd_full_stall_wait", s_rd_waitrequest, 1);
    chk("rd_full_stall_read", m_rd_read, 0);
    step();
    m_rd_readdatavalid = 1;
    step();
    m_rd_readdatavalid = 0; #1;
    chk("rd_127", rd_beats_outstanding, 127);
    chk("rd_reaccept", m_rd_read, 1);
    step();
    s_rd_read = 0;
    chk("rd_back_128", rd_beats_outstanding, 128);

    m_rd_readdatavalid = 1;
    repeat (8) step();
    chk("rd_120", rd_beats_outstanding, 120);
    s_rd_read = 1; s_rd_burstcount = 16; #1;
    chk("rd16_stall", s_rd_waitrequest, 1);
    repeat (8) step();
    chk("rd_112", rd_beats_outstanding, 112);
    chk("rd16_go", m_rd_read, 1);
    step();
    s_rd_read = 0; m_rd_readdatavalid = 0;
    chk("rd_net_127", rd_beats_outstanding, 127);

    m_rd_waitrequest = 1; s_rd_read = 1; s_rd_burstcount = 1; #1;
    chk("rd_shim_wait", s_rd_waitrequest, 1);
    chk("rd_shim_read", m_rd_read, 1);
    step();
    chk("rd_shim_cnt", rd_beats_outstanding, 127);
    m_rd_waitrequest = 0; s_rd_read = 0;
    m_rd_readdatavalid = 1;
    repeat (127) step();
    m_rd_readdatavalid = 0;
    chk("rd_drained", rd_beats_outstanding, 0);

    s_wr_write = 1; s_wr_burstcount = 4;
    repeat (4) step();
    chk("wr_burst1", wr_bursts_outstanding, 1);
    step();
    chk("wr_burst2_sop", wr_bursts_outstanding, 2);
    chk("wr_burst2_unstalled", s_wr_waitrequest, 0);
    repeat (3) step();
    chk("wr_sop_stall_wait", s_wr_waitrequest, 1);
    chk("wr_sop_stall_write", m_wr_write, 0);
    step();
    chk("wr_stalled_cnt", wr_bursts_outstanding, 2);
    m_wr_writeresponsevalid = 1;
    step();
    m_wr_writeresponsevalid = 0; #1;
    chk("wr_after_resp", wr_bursts_outstanding, 1);
    chk("wr_third_sop", m_wr_write, 1);
    s_wr_burstcount = 1; m_wr_writeresponsevalid = 1;
    step();
    m_wr_writeresponsevalid = 0;
    chk("wr_net_zero", wr_bursts_outstanding, 1);
    step();
    chk("wr_single_beat", wr_bursts_outstanding, 2);
    chk("wr_single_sop_stall", s_wr_waitrequest, 1);
    s_wr_write = 0; m_wr_writeresponsevalid = 1;
    step(); step();
    m_wr_writeresponsevalid = 0;
    chk("wr_drained", wr_bursts_outstanding, 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
